// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response bus between the LSU and the memory.
// master = LSU side, slave = memory side.
interface lsu_mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [3:0]        mem_req_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen,
    output mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen,
    input  mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: runs one load/store at a time against data memory
// and emits a single-cycle writeback beat.
module lsu_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  lsu_mem_stage_if.master   mem,
  output logic              out_valid,
  output logic [4:0]        gpr_waddr,
  output logic [XLEN-1:0]   gpr_wdata,
  output logic              gpr_wen,
  output logic              out_fault
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_RSP, DONE
  } state_t;

  state_t state, nxt;

  logic              st_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic [4:0]        rd_r;
  logic              rd_wen_r;

  logic mem_op, illegal, misalign, fault_in;
  logic take, skip_mem, rsp_hit;

  assign mem_op   = in_is_load | in_is_store;
  assign take     = (state == IDLE) & in_valid;
  assign rsp_hit  = (state == WAIT_RSP) & mem.mem_rsp_valid;

  always_comb begin
    illegal  = 1'b1;
    misalign = 1'b0;
    if (in_is_store)
      illegal = !(in_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(in_funct3 inside
        {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    unique case (in_funct3[1:0])
      2'b01:   misalign = in_addr[0];
      2'b10:   misalign = |in_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign fault_in = mem_op & (illegal | misalign);
  assign skip_mem = !mem_op | fault_in;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (in_valid) nxt = skip_mem ? DONE : REQ;
      REQ:      if (mem.mem_req_ready) nxt = WAIT_RSP;
      WAIT_RSP: if (mem.mem_rsp_valid) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Store lanes are replicated so the memory can pick any byte enable.
  always_comb begin
    mem.mem_req_valid = (state == REQ);
    mem.mem_req_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    mem.mem_req_wen   = st_r;
    mem.mem_req_wdata = wdata_r;
    mem.mem_req_wmask = 4'b1111;
    unique case (funct3_r[1:0])
      2'b00: begin
        mem.mem_req_wdata = {4{wdata_r[7:0]}};
        mem.mem_req_wmask = 4'b0001 << addr_r[1:0];
      end
      2'b01: begin
        mem.mem_req_wdata = {2{wdata_r[15:0]}};
        mem.mem_req_wmask = 4'b0011 << addr_r[1:0];
      end
      default: begin
        mem.mem_req_wdata = wdata_r;
        mem.mem_req_wmask = 4'b1111;
      end
    endcase
    if (!st_r) mem.mem_req_wmask = 4'b0000;
  end

  logic [XLEN-1:0] sh, ld_data;

  always_comb begin
    sh = mem.mem_rsp_rdata >> {addr_r[1:0], 3'b000};
    unique case (funct3_r)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_data = {24'd0, sh[7:0]};
      3'b101:  ld_data = {16'd0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st_r      <= 1'b0;
      funct3_r  <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rd_r      <= '0;
      rd_wen_r  <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      gpr_wen   <= 1'b0;
      out_fault <= 1'b0;
    end else begin
      gpr_wen   <= 1'b0;
      out_fault <= 1'b0;
      if (take) begin
        st_r     <= in_is_store;
        funct3_r <= in_funct3;
        addr_r   <= in_addr;
        wdata_r  <= in_wdata;
        rd_r     <= in_rd;
        rd_wen_r <= in_rd_wen;
      end
      if (take && skip_mem) begin
        gpr_waddr <= in_rd;
        gpr_wdata <= in_alu_result;
        gpr_wen   <= in_rd_wen & !in_is_store & !fault_in & (|in_rd);
        out_fault <= fault_in;
      end
      if (rsp_hit) begin
        gpr_waddr <= rd_r;
        gpr_wdata <= ld_data;
        gpr_wen   <= rd_wen_r & !st_r & (|rd_r);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: scoreboard of writeback beats
// plus direct checks of the memory request side.
module tb_lsu_mem_stage;

  logic        sys_clk;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        out_valid;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        gpr_wen;
  logic        out_fault;

  lsu_mem_stage_if #(.ADDR_W(32), .XLEN(32)) mem ();

  lsu_mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_alu_result (in_alu_result),
    .in_rd         (in_rd),
    .in_rd_wen     (in_rd_wen),
    .mem           (mem),
    .out_valid     (out_valid),
    .gpr_waddr     (gpr_waddr),
    .gpr_wdata     (gpr_wdata),
    .gpr_wen       (gpr_wen),
    .out_fault     (out_fault)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        data_v;
    logic        wen;
    logic        fault;
  } wb_t;

  wb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          wb_t e;
          e = sbq.pop_front();
          chk("gpr_waddr", 32'(gpr_waddr), 32'(e.rd));
          chk("gpr_wen", 32'(gpr_wen), 32'(e.wen));
          chk("out_fault", 32'(out_fault), 32'(e.fault));
          if (e.data_v) chk("gpr_wdata", gpr_wdata, e.data);
        end
      end else begin
        chk("wen_idle", 32'(gpr_wen), 32'd0);
      end
    end
  end

  function automatic wb_t mk(input logic [4:0] rd, input logic [31:0] d,
                             input logic dv, input logic w,
                             input logic f);
    wb_t r;
    r.rd = rd; r.data = d; r.data_v = dv; r.wen = w; r.fault = f;
    return r;
  endfunction

  task automatic send(input logic ld, input logic st,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] alu,
                      input logic [4:0] rd, input logic rdw,
                      input bit push, input wb_t exp);
    int n = 0;
    @(negedge sys_clk);
    while (!in_ready && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("in_ready", 32'(in_ready), 32'd1);
    in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = a; in_wdata = wd; in_alu_result = alu;
    in_rd = rd; in_rd_wen = rdw; in_valid = 1'b1;
    if (push) sbq.push_back(exp);
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic mem_serve(input int rdy_wait, input int rsp_wait,
                           input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_wen,
                           input logic [31:0] e_wdata,
                           input logic [3:0] e_mask);
    int n = 0;
    @(negedge sys_clk);
    while (!mem.mem_req_valid && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("req_valid", 32'(mem.mem_req_valid), 32'd1);
    for (int i = 0; i < rdy_wait; i++) begin
      chk("req_hold_valid", 32'(mem.mem_req_valid), 32'd1);
      chk("req_hold_addr", mem.mem_req_addr, e_addr);
      @(negedge sys_clk);
    end
    mem.mem_req_ready = 1'b1;
    chk("req_addr", mem.mem_req_addr, e_addr);
    chk("req_wen", 32'(mem.mem_req_wen), 32'(e_wen));
    chk("req_wmask", 32'(mem.mem_req_wmask), 32'(e_mask));
    if (e_wen) chk("req_wdata", mem.mem_req_wdata, e_wdata);
    @(posedge sys_clk);
    #1 mem.mem_req_ready = 1'b0;
    @(negedge sys_clk);
    chk("req_drop", 32'(mem.mem_req_valid), 32'd0);
    repeat (rsp_wait) @(negedge sys_clk);
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = rdata;
    @(posedge sys_clk);
    #1 mem.mem_rsp_valid = 1'b0;
  endtask

  task automatic no_req_window();
    repeat (3) begin
      @(negedge sys_clk);
      chk("no_req", 32'(mem.mem_req_valid), 32'd0);
    end
  endtask

  wb_t nul;

  initial begin
    nul = mk(5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = '0; in_addr = '0; in_wdata = '0;
    in_alu_result = '0; in_rd = '0; in_rd_wen = 1'b0;
    mem.mem_req_ready = 1'b0;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rsp_rdata = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(mem.mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_gpr_wen", 32'(gpr_wen), 32'd0);
    chk("rst_gpr_waddr", 32'(gpr_waddr), 32'd0);
    chk("rst_gpr_wdata", gpr_wdata, 32'd0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    sys_rst = 1'b0;

    // non-memory pass-through
    send(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h12345678, 5'd5, 1'b1,
         1'b1, mk(5'd5, 32'h12345678, 1'b1, 1'b1, 1'b0));
    @(negedge sys_clk);
    chk("nm_latency", 32'(out_valid), 32'd1);
    chk("nm_busy", 32'(in_ready), 32'd0);
    @(negedge sys_clk);
    chk("nm_ready_again", 32'(in_ready), 32'd1);

    // LB / LBU with 3 cycles of back-pressure
    send(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h0, 5'd7, 1'b1,
         1'b1, mk(5'd7, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0));
    mem_serve(3, 0, 32'h80FF1122, 32'h80000000, 1'b0, 32'h0, 4'b0000);
    send(1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0, 32'h0, 5'd8, 1'b1,
         1'b1, mk(5'd8, 32'h00000080, 1'b1, 1'b1, 1'b0));
    mem_serve(0, 2, 32'h80FF1122, 32'h80000000, 1'b0, 32'h0, 4'b0000);

    // LH / LHU upper half
    send(1'b1, 1'b0, 3'b001, 32'h00000012, 32'h0, 32'h0, 5'd9, 1'b1,
         1'b1, mk(5'd9, 32'hFFFFBEEF, 1'b1, 1'b1, 1'b0));
    mem_serve(0, 0, 32'hBEEF1234, 32'h00000010, 1'b0, 32'h0, 4'b0000);
    send(1'b1, 1'b0, 3'b101, 32'h00000012, 32'h0, 32'h0, 5'd10, 1'b1,
         1'b1, mk(5'd10, 32'h0000BEEF, 1'b1, 1'b1, 1'b0));
    mem_serve(1, 1, 32'hBEEF1234, 32'h00000010, 1'b0, 32'h0, 4'b0000);

    // stores
    send(1'b0, 1'b1, 3'b001, 32'h80000102, 32'hAAAABEEF, 32'h0, 5'd3,
         1'b1, 1'b1, mk(5'd3, 32'h0, 1'b0, 1'b0, 1'b0));
    mem_serve(0, 0, 32'h0, 32'h80000100, 1'b1, 32'hBEEFBEEF, 4'b1100);
    send(1'b0, 1'b1, 3'b000, 32'h00000041, 32'h1234565A, 32'h0, 5'd4,
         1'b1, 1'b1, mk(5'd4, 32'h0, 1'b0, 1'b0, 1'b0));
    mem_serve(0, 0, 32'h0, 32'h00000040, 1'b1, 32'h5A5A5A5A, 4'b0010);
    send(1'b0, 1'b1, 3'b010, 32'h00000080, 32'hCAFEF00D, 32'h0, 5'd4,
         1'b1, 1'b1, mk(5'd4, 32'h0, 1'b0, 1'b0, 1'b0));
    mem_serve(2, 0, 32'h0, 32'h00000080, 1'b1, 32'hCAFEF00D, 4'b1111);

    // faults: misaligned LW, illegal funct3, misaligned SH
    send(1'b1, 1'b0, 3'b010, 32'h80000006, 32'h0, 32'h0, 5'd6, 1'b1,
         1'b1, mk(5'd6, 32'h0, 1'b0, 1'b0, 1'b1));
    no_req_window();
    send(1'b1, 1'b0, 3'b011, 32'h80000008, 32'h0, 32'h0, 5'd6, 1'b1,
         1'b1, mk(5'd6, 32'h0, 1'b0, 1'b0, 1'b1));
    no_req_window();
    send(1'b0, 1'b1, 3'b001, 32'h80000001, 32'h0, 32'h0, 5'd6, 1'b1,
         1'b1, mk(5'd6, 32'h0, 1'b0, 1'b0, 1'b1));
    no_req_window();

    // spurious response in IDLE, then LW to x0
    @(negedge sys_clk);
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = 32'h11111111;
    @(posedge sys_clk);
    #1 mem.mem_rsp_valid = 1'b0;
    @(negedge sys_clk);
    chk("spurious_out_valid", 32'(out_valid), 32'd0);
    chk("spurious_in_ready", 32'(in_ready), 32'd1);
    send(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0, 32'h0, 5'd0, 1'b1,
         1'b1, mk(5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0));
    mem_serve(0, 0, 32'hDEADBEEF, 32'h00000100, 1'b0, 32'h0, 4'b0000);

    // reset while a load sits in REQ
    send(1'b1, 1'b0, 3'b010, 32'h00000200, 32'h0, 32'h0, 5'd11, 1'b1,
         1'b0, nul);
    @(negedge sys_clk);
    chk("abort_req_valid", 32'(mem.mem_req_valid), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("abort_req_drop", 32'(mem.mem_req_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    @(negedge sys_clk);
    mem.mem_rsp_valid = 1'b1;
    mem.mem_rsp_rdata = 32'h55555555;
    @(posedge sys_clk);
    #1 mem.mem_rsp_valid = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      chk("abort_no_wb", 32'(out_valid), 32'd0);
    end

    // post-reset sanity
    send(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hA5A5A5A5, 5'd31, 1'b1,
         1'b1, mk(5'd31, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0));

    for (int i = 0; i < 20 && sbq.size() != 0; i++)
      @(negedge sys_clk);
    @(negedge sys_clk);
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
